// File: rtl/psc_pkg.sv
// Shared types and constants for the phased signal controller.
package psc_pkg;

  // Controller states; lamp drives are decoded from these.
  typedef enum logic [2:0] {
    ST_GREEN,
    ST_YELLOW,
    ST_ALL_RED,
    ST_PED_WALK,
    ST_EMG_ALL_RED,
    ST_EMG_GREEN
  } psc_state_e;

  // Width of the per-state tick timer and green extension counter.
  localparam int TIMER_W = 16;

  // Bits needed to hold a phase index; never narrower than one bit.
  function automatic int phase_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/psc_tick_gen.sv
// Timebase: one-clk tick every PRESCALE_MAX clocks.
module psc_tick_gen #(
  parameter int PRESCALE_MAX = 1000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int CW = (PRESCALE_MAX <= 2) ? 1 : $clog2(PRESCALE_MAX);
  localparam logic [CW-1:0] LAST = CW'(PRESCALE_MAX - 1);

  logic [CW-1:0] count_reg;

  // Free-running modulo-PRESCALE_MAX counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (count_reg == LAST) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_reg + CW'(1);
    end
  end

  assign tick = (count_reg == LAST);

endmodule

// File: rtl/phased_signal_controller.sv
// Multi-phase traffic signal controller with detector extension,
// exclusive pedestrian walk and emergency preemption.
module phased_signal_controller
  import psc_pkg::*;
#(
  parameter int NUM_PHASES   = 4,
  parameter int PRESCALE_MAX = 1000,
  parameter int T_GREEN_MIN  = 8,
  parameter int T_GREEN_MAX  = 16,
  parameter int T_YELLOW     = 3,
  parameter int T_ALL_RED    = 2,
  parameter int T_PED        = 6,
  parameter int T_EMG        = 15,
  localparam int PW          = phase_w(NUM_PHASES)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_PHASES-1:0] ped_req,
  input  logic [NUM_PHASES-1:0] car_det,
  input  logic                  emg_req,
  input  logic [PW-1:0]         emg_phase,
  input  logic                  emg_clear,
  output logic [NUM_PHASES-1:0] green,
  output logic [NUM_PHASES-1:0] yellow,
  output logic [NUM_PHASES-1:0] walk,
  output logic                  all_red,
  output logic [PW-1:0]         cur_phase,
  output logic                  emg_active
);

  // Timer load values: a state lasting T ticks loads T-1 and exits at 0.
  localparam logic [TIMER_W-1:0] LD_GREEN   = TIMER_W'(T_GREEN_MIN - 1);
  localparam logic [TIMER_W-1:0] LD_EXT     = TIMER_W'(T_GREEN_MAX - T_GREEN_MIN);
  localparam logic [TIMER_W-1:0] LD_YELLOW  = TIMER_W'(T_YELLOW - 1);
  localparam logic [TIMER_W-1:0] LD_ALL_RED = TIMER_W'(T_ALL_RED - 1);
  localparam logic [TIMER_W-1:0] LD_PED     = TIMER_W'(T_PED - 1);
  localparam logic [TIMER_W-1:0] LD_EMG     = TIMER_W'(T_EMG - 1);
  localparam logic [PW-1:0]      LAST_PHASE = PW'(NUM_PHASES - 1);

  logic                  tick;
  psc_state_e            state_reg, state_next;
  logic [TIMER_W-1:0]    timer_reg, timer_next;
  logic [TIMER_W-1:0]    ext_reg, ext_next;
  logic [PW-1:0]         cur_phase_reg, cur_phase_next;
  logic [NUM_PHASES-1:0] ped_latch_reg, ped_latch_next;
  logic [NUM_PHASES-1:0] walk_reg, walk_next;
  logic                  after_ped_reg, after_ped_next;
  logic                  emg_active_reg, emg_active_next;
  logic [PW-1:0]         emg_phase_reg, emg_phase_next;
  logic                  emg_clear_reg, emg_clear_next;
  logic [NUM_PHASES-1:0] green_reg, green_next;
  logic [NUM_PHASES-1:0] yellow_reg, yellow_next;
  logic                  all_red_reg, all_red_next;
  logic [NUM_PHASES-1:0] cur_onehot, next_onehot;
  logic [PW-1:0]         emg_phase_safe;
  logic [PW-1:0]         phase_inc;

  psc_tick_gen #(
    .PRESCALE_MAX(PRESCALE_MAX)
  ) u_tick_gen (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (tick)
  );

  // Out-of-range emergency phase requests fall back to phase 0.
  if (NUM_PHASES == (1 << PW)) begin : g_phase_full
    assign emg_phase_safe = emg_phase;
  end else begin : g_phase_map
    assign emg_phase_safe = (emg_phase < PW'(NUM_PHASES)) ? emg_phase : '0;
  end

  // One-hot decode of the current and upcoming phase index.
  genvar gi;
  for (gi = 0; gi < NUM_PHASES; gi++) begin : g_onehot
    assign cur_onehot[gi]  = (cur_phase_reg == PW'(gi));
    assign next_onehot[gi] = (cur_phase_next == PW'(gi));
  end

  assign phase_inc = (cur_phase_reg == LAST_PHASE) ? '0 : cur_phase_reg + PW'(1);

  // State, timers and request latches; reset abandons walk and emergency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_ALL_RED;
      timer_reg      <= LD_ALL_RED;
      ext_reg        <= '0;
      cur_phase_reg  <= LAST_PHASE;
      ped_latch_reg  <= '0;
      walk_reg       <= '0;
      after_ped_reg  <= 1'b0;
      emg_active_reg <= 1'b0;
      emg_phase_reg  <= '0;
      emg_clear_reg  <= 1'b0;
      green_reg      <= '0;
      yellow_reg     <= '0;
      all_red_reg    <= 1'b1;
    end else begin
      state_reg      <= state_next;
      timer_reg      <= timer_next;
      ext_reg        <= ext_next;
      cur_phase_reg  <= cur_phase_next;
      ped_latch_reg  <= ped_latch_next;
      walk_reg       <= walk_next;
      after_ped_reg  <= after_ped_next;
      emg_active_reg <= emg_active_next;
      emg_phase_reg  <= emg_phase_next;
      emg_clear_reg  <= emg_clear_next;
      green_reg      <= green_next;
      yellow_reg     <= yellow_next;
      all_red_reg    <= all_red_next;
    end
  end

  // Next-state logic: request latching on every clk, sequencing on tick.
  always_comb begin
    state_next      = state_reg;
    timer_next      = timer_reg;
    ext_next        = ext_reg;
    cur_phase_next  = cur_phase_reg;
    ped_latch_next  = ped_latch_reg | ped_req;
    walk_next       = walk_reg;
    after_ped_next  = after_ped_reg;
    emg_active_next = emg_active_reg;
    emg_phase_next  = emg_phase_reg;
    emg_clear_next  = emg_clear_reg;

    // A new request wins over a simultaneous clear; clears before service are kept.
    if (emg_req && !emg_active_reg) begin
      emg_active_next = 1'b1;
      emg_phase_next  = emg_phase_safe;
      emg_clear_next  = 1'b0;
    end else if (emg_clear && emg_active_reg) begin
      emg_clear_next = 1'b1;
    end

    if (tick) begin
      case (state_reg)
        ST_GREEN: begin
          if (emg_active_reg) begin
            if (cur_phase_reg == emg_phase_reg) begin
              state_next = ST_EMG_GREEN;
              timer_next = LD_EMG;
            end else begin
              state_next = ST_YELLOW;
              timer_next = LD_YELLOW;
            end
          end else if (timer_reg != '0) begin
            timer_next = timer_reg - TIMER_W'(1);
          end else if (|(car_det & cur_onehot) && ext_reg != '0) begin
            ext_next = ext_reg - TIMER_W'(1);
          end else begin
            state_next = ST_YELLOW;
            timer_next = LD_YELLOW;
          end
        end
        ST_YELLOW: begin
          if (timer_reg != '0) begin
            timer_next = timer_reg - TIMER_W'(1);
          end else begin
            state_next = emg_active_reg ? ST_EMG_ALL_RED : ST_ALL_RED;
            timer_next = LD_ALL_RED;
          end
        end
        ST_ALL_RED: begin
          if (emg_active_reg) begin
            state_next     = ST_EMG_ALL_RED;
            timer_next     = LD_ALL_RED;
            after_ped_next = 1'b0;
          end else if (timer_reg != '0) begin
            timer_next = timer_reg - TIMER_W'(1);
          end else if (|ped_latch_reg && !after_ped_reg) begin
            // The whole latch is snapshotted, so only fresh requests remain.
            state_next     = ST_PED_WALK;
            timer_next     = LD_PED;
            walk_next      = ped_latch_reg;
            ped_latch_next = ped_req;
          end else begin
            state_next     = ST_GREEN;
            timer_next     = LD_GREEN;
            ext_next       = LD_EXT;
            cur_phase_next = phase_inc;
            after_ped_next = 1'b0;
          end
        end
        ST_PED_WALK: begin
          if (emg_active_reg) begin
            // An aborted walk was not served, so its crossings stay pending.
            state_next     = ST_EMG_ALL_RED;
            timer_next     = LD_ALL_RED;
            ped_latch_next = ped_latch_reg | walk_reg | ped_req;
            walk_next      = '0;
            after_ped_next = 1'b0;
          end else if (timer_reg != '0) begin
            timer_next = timer_reg - TIMER_W'(1);
          end else begin
            state_next     = ST_ALL_RED;
            timer_next     = LD_ALL_RED;
            walk_next      = '0;
            after_ped_next = 1'b1;
          end
        end
        ST_EMG_ALL_RED: begin
          if (timer_reg != '0) begin
            timer_next = timer_reg - TIMER_W'(1);
          end else begin
            state_next     = ST_EMG_GREEN;
            timer_next     = LD_EMG;
            cur_phase_next = emg_phase_reg;
          end
        end
        ST_EMG_GREEN: begin
          if (timer_reg != '0) begin
            timer_next = timer_reg - TIMER_W'(1);
          end else if (emg_clear_reg || emg_clear) begin
            state_next      = ST_YELLOW;
            timer_next      = LD_YELLOW;
            emg_active_next = 1'b0;
            emg_clear_next  = 1'b0;
          end
        end
        default: begin
          state_next = ST_ALL_RED;
          timer_next = LD_ALL_RED;
        end
      endcase
    end
  end

  // Lamp decode from the upcoming state so the lamp registers track it.
  always_comb begin
    green_next  = '0;
    yellow_next = '0;
    case (state_next)
      ST_GREEN, ST_EMG_GREEN: green_next  = next_onehot;
      ST_YELLOW:              yellow_next = next_onehot;
      default:                ;
    endcase
    all_red_next = ~(|green_next | |yellow_next);
  end

  assign green      = green_reg;
  assign yellow     = yellow_reg;
  assign walk       = walk_reg;
  assign all_red    = all_red_reg;
  assign cur_phase  = cur_phase_reg;
  assign emg_active = emg_active_reg;

endmodule

// File: doc/phased_signal_controller.md
PHASED_SIGNAL_CONTROLLER -- requirements
Module: phased_signal_controller

Interface
REQ-001 NUM_PHASES, 4, number of conflicting approaches served in rotation (2..8).
REQ-002 PRESCALE_MAX, 1000, clk cycles per tick (>=2).
REQ-003 T_GREEN_MIN, 8, minimum green ticks.
REQ-004 T_GREEN_MAX, 16, maximum green ticks with detector extension (>=T_GREEN_MIN).
REQ-005 T_YELLOW, 3, yellow ticks.
REQ-006 T_ALL_RED, 2, clearance ticks.
REQ-007 T_PED, 6, exclusive pedestrian walk ticks.
REQ-008 T_EMG, 15, minimum emergency green ticks.
REQ-009 clk  input  1  clock.
REQ-010 rst_n  input  1  reset, asynchronous, active-low.
REQ-011 ped_req  input  NUM_PHASES  per-crossing walk request, level or pulse.
REQ-012 car_det  input  NUM_PHASES  per-approach vehicle detector.
REQ-013 emg_req  input  1  emergency request pulse.
REQ-014 emg_phase  input  PW=max(1,clog2(NUM_PHASES))  phase to serve, sampled with emg_req.
REQ-015 emg_clear  input  1  emergency clear pulse.
REQ-016 green, yellow, walk  output  NUM_PHASES each  registered one-hot lamp drives.
REQ-017 all_red  output  1  high when no green or yellow is lit.
REQ-018 cur_phase  output  PW  phase index of current or last green.
REQ-019 emg_active  output  1  emergency latched or being served.

Function
REQ-020 tick SHALL pulse one clk every PRESCALE_MAX clks; all timing SHALL advance only on tick.
REQ-021 A state entered with duration T SHALL last exactly T ticks (timer loads T-1, exits on tick with timer==0).
REQ-022 States: GREEN, YELLOW, ALL_RED, PED_WALK, EMG_ALL_RED, EMG_GREEN.
REQ-023 Normal rotation: GREEN(p) -> YELLOW(p) -> ALL_RED -> GREEN((p+1) mod NUM_PHASES), wrap from NUM_PHASES-1 to 0.
REQ-024 GREEN SHALL exit after T_GREEN_MIN ticks if car_det[p]==0 at that tick, else extend per tick while car_det[p]==1, hard-capped at T_GREEN_MAX ticks.
REQ-025 ped_req bits SHALL latch per crossing on any clk; latch clears only when that crossing's walk is served.
REQ-026 At ALL_RED exit, if any latch set and last state was not PED_WALK: enter PED_WALK, walk = latch snapshot, snapshot bits cleared at entry; then ALL_RED, then next green.
REQ-027 Requests arriving during PED_WALK SHALL stay latched for the next cycle.
REQ-028 emg_req SHALL latch emg_active and capture emg_phase (values >=NUM_PHASES map to 0); emg_req during active emergency SHALL be ignored.
REQ-029 Preemption at next tick: GREEN(emg_phase) -> EMG_GREEN directly; other GREEN -> YELLOW immediately; YELLOW completes; ALL_RED/PED_WALK abort to EMG_ALL_RED (walk drops same clock); YELLOW exits to EMG_ALL_RED.
REQ-030 EMG_ALL_RED lasts T_ALL_RED ticks then EMG_GREEN, green[emg_phase]=1.
REQ-031 EMG_GREEN SHALL exit only after T_EMG ticks and emg_clear seen; then YELLOW(emg_phase), ALL_RED, resume at emg_phase+1; emg_active drops at YELLOW entry.
REQ-032 emg_clear before EMG_GREEN SHALL be remembered; emg_req and emg_clear same clk: request wins.
REQ-033 At most one green or yellow bit SHALL ever be high; walk SHALL never coincide with green/yellow.

Reset
REQ-034 Reset SHALL clear prescaler, timer, latches, emg_active; state ALL_RED, cur_phase=NUM_PHASES-1.
REQ-035 Reset outputs: green=0, yellow=0, walk=0, all_red=1, emg_active=0; first green is phase 0 after T_ALL_RED ticks.
REQ-036 Reset mid-operation SHALL abandon any walk or emergency immediately.

Structure
REQ-037 Package psc_pkg SHALL hold state enum and timer width constant.
REQ-038 Prescaler SHALL be sub-module psc_tick_gen.

Verification (NUM_PHASES=4, PRESCALE_MAX=4, T_GREEN_MIN=3, T_GREEN_MAX=6, T_YELLOW=2, T_ALL_RED=1, T_PED=2, T_EMG=3)
REQ-039 No inputs -> green 0,1,2,3,0 each 3 ticks (12 clk), yellow 2 ticks, all_red 1 tick.
REQ-040 car_det[1] held high -> green[1] lasts 6 ticks; dropped at tick 4 -> green[1] ends after tick 4.
REQ-041 ped_req[2] pulse during green[0] -> after ALL_RED, walk=4'b0100 for 2 ticks, ALL_RED, then green[1].
REQ-042 emg_req with emg_phase=3 during green[0] -> yellow[0] 2 ticks, all_red 1 tick, green[3] held until emg_clear (>=3 ticks), then yellow[3], ALL_RED, green[0].
REQ-043 emg_req during PED_WALK -> walk drops next tick, EMG_ALL_RED, green[emg_phase]; pending ped latches preserved.
REQ-044 rst_n low mid EMG_GREEN -> outputs at reset values asynchronously; restart at phase 0.
